// File: rtl/amp_wave_pwm_pkg.sv
// Shared constants for the amplitude-scaled triangle PWM generator.
// Also provides the BCD digit clamp used by the setting consumers.
package amp_wave_pwm_pkg;

  localparam int PWM_W    = 8;
  localparam int SCALE_K  = 662;
  localparam int SCALE_SH = 16;
  localparam int BCD_MAX  = 9;
  localparam int PROD_W   = 25;

  // An out-of-range nibble is treated as the largest legal digit.
  function automatic logic [3:0] clampDigit(input logic [3:0] digit);
    return (digit > 4'(BCD_MAX)) ? 4'(BCD_MAX) : digit;
  endfunction

endpackage

// File: rtl/amp_wave_pwm_bcd2bin_clamp.sv
// Registered two-digit BCD to binary conversion, clamping each illegal nibble to 9.
// The result spans 0..99.
module bcd2bin_clamp
  import amp_wave_pwm_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_bcd,
  output logic [6:0] o_bin
);

  logic [3:0] w_tens;
  logic [3:0] w_ones;
  logic [6:0] w_bin;
  logic [6:0] r_bin;

  assign w_tens = clampDigit(i_bcd[7:4]);
  assign w_ones = clampDigit(i_bcd[3:0]);
  assign w_bin  = (7'(w_tens) * 7'd10) + 7'(w_ones);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bin <= '0;
    end else begin
      r_bin <= w_bin;
    end
  end

  assign o_bin = r_bin;

endmodule

// File: rtl/amp_wave_pwm.sv
// Triangle-wave generator scaled by a BCD amplitude percentage.
// Drives one-bit PWM for an RC DAC and exposes the 8-bit sample.
module amp_wave_pwm
  import amp_wave_pwm_pkg::*;
#(
  parameter int PHASE_W = 24,
  parameter int PWM_W   = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic [7:0]         i_amp_bcd,
  input  logic [PHASE_W-1:0] i_freq_word,
  output logic               o_pwm_out,
  output logic [PWM_W-1:0]   o_sample,
  output logic               o_sample_valid
);

  logic [PWM_W-1:0]   r_cnt;
  logic [PHASE_W-1:0] r_phase;
  logic [6:0]         r_ampLat;
  logic [PWM_W-1:0]   r_scaled;
  logic [PWM_W-1:0]   r_sample;
  logic               r_sampleValid;
  logic               r_pwm;

  logic [6:0]         w_ampBin;
  logic               w_wrap;
  logic [PWM_W-1:0]   w_t;
  logic [PWM_W-1:0]   w_tri;
  logic [PROD_W-1:0]  w_product;
  logic [PWM_W-1:0]   w_scaled;

  bcd2bin_clamp u_bcd2bin (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_bcd   (i_amp_bcd),
    .o_bin   (w_ampBin)
  );

  assign w_wrap = i_en && (r_cnt == '1);

  // Reflect the rising ramp in the upper half of the phase to get one peak per cycle.
  assign w_t       = r_phase[PHASE_W-2 -: PWM_W];
  assign w_tri     = r_phase[PHASE_W-1] ? ~w_t : w_t;
  assign w_product = PROD_W'(w_tri) * PROD_W'(r_ampLat) * PROD_W'(SCALE_K);
  assign w_scaled  = PWM_W'(w_product >> SCALE_SH);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (!i_en) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Phase and amplitude only move on a wrap, so the product has a whole period to settle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_scaled <= '0;
    end else begin
      r_scaled <= w_scaled;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sample      <= '0;
      r_phase       <= '0;
      r_ampLat      <= '0;
      r_sampleValid <= 1'b0;
    end else begin
      r_sampleValid <= w_wrap;
      if (w_wrap) begin
        r_sample <= r_scaled;
        r_phase  <= r_phase + i_freq_word;
        r_ampLat <= w_ampBin;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pwm <= 1'b0;
    end else begin
      r_pwm <= i_en && (r_cnt < r_sample);
    end
  end

  assign o_pwm_out      = r_pwm;
  assign o_sample       = r_sample;
  assign o_sample_valid = r_sampleValid;

endmodule

// File: tb/tb_amp_wave_pwm.sv
// Directed bench for amp_wave_pwm: vector table of amplitude/frequency settings
// plus hand-written sequences for mid-period changes, enable gating and async reset.
module tb_amp_wave_pwm;

  logic        clk = 1'b0;
  logic        rstN;
  logic        en;
  logic [7:0]  ampBcd;
  logic [23:0] freqWord;
  logic        pwmOut;
  logic [7:0]  sample;
  logic        sampleValid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  amp_wave_pwm #(.PHASE_W(24), .PWM_W(8)) dut (
    .i_clk          (clk),
    .i_rst_n        (rstN),
    .i_en           (en),
    .i_amp_bcd      (ampBcd),
    .i_freq_word    (freqWord),
    .o_pwm_out      (pwmOut),
    .o_sample       (sample),
    .o_sample_valid (sampleValid)
  );

  typedef struct packed {
    logic [7:0]      bcd;
    logic [23:0]     freq;
    logic [4:0][7:0] exp;
  } vec_t;

  vec_t vecs[7];

  function automatic vec_t mkVec(input logic [7:0] b, input logic [23:0] f,
                                 input int e0, input int e1, input int e2,
                                 input int e3, input int e4);
    vec_t v;
    v.bcd    = b;
    v.freq   = f;
    v.exp[0] = 8'(e0);
    v.exp[1] = 8'(e1);
    v.exp[2] = 8'(e2);
    v.exp[3] = 8'(e3);
    v.exp[4] = 8'(e4);
    return v;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic [23:0] f, input logic e);
    ampBcd   = b;
    freqWord = f;
    en       = e;
  endtask

  task automatic resetDut();
    rstN = 1'b0;
    repeat (3) tick();
    rstN = 1'b1;
  endtask

  // Advances until the next sample_valid pulse, counting clocks and PWM-high clocks.
  task automatic waitValid(input int budget, output int cycles, output int highs);
    cycles = 0;
    highs  = 0;
    while (cycles < budget) begin
      tick();
      cycles++;
      highs += int'(pwmOut);
      if (sampleValid) return;
    end
    checks++;
    errors++;
    $display("[TB] FAIL wait_valid: no sample_valid within %0d clocks", budget);
  endtask

  // Checks a run of wraps: spacing, PWM duty of the previous sample, new sample value.
  task automatic checkWraps(input string tag, input int n, input int prevStart,
                            input int e0, input int e1, input int e2, input int e3);
    int cycles, highs, prev, expv;
    prev = prevStart;
    for (int w = 0; w < n; w++) begin
      expv = (w == 0) ? e0 : (w == 1) ? e1 : (w == 2) ? e2 : e3;
      waitValid(600, cycles, highs);
      checkOutput($sformatf("%s_spacing%0d", tag, w), cycles, 256);
      checkOutput($sformatf("%s_highs%0d", tag, w), highs, prev);
      checkOutput($sformatf("%s_sample%0d", tag, w), int'(sample), expv);
      prev = expv;
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cycles, highs, cnt, prev;

    rstN = 1'b0;
    applyStimulus(8'h00, 24'h0, 1'b0);

    vecs[0] = mkVec(8'h99, 24'h400000, 0, 128, 255, 127, 0);
    vecs[1] = mkVec(8'h50, 24'h400000, 0, 64, 128, 64, 0);
    vecs[2] = mkVec(8'h25, 24'h400000, 0, 32, 64, 32, 0);
    vecs[3] = mkVec(8'h00, 24'h400000, 0, 0, 0, 0, 0);
    vecs[4] = mkVec(8'hAF, 24'h400000, 0, 128, 255, 127, 0);
    vecs[5] = mkVec(8'h99, 24'h200000, 0, 64, 128, 192, 255);
    vecs[6] = mkVec(8'h5F, 24'h400000, 0, 76, 151, 75, 0);

    $display("[TB] reset held with toggling inputs");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(8'(i * 37), 24'($urandom), 1'(i % 2));
      tick();
      checkOutput($sformatf("rst_pwm%0d", i), int'(pwmOut), 0);
      checkOutput($sformatf("rst_sample%0d", i), int'(sample), 0);
      checkOutput($sformatf("rst_valid%0d", i), int'(sampleValid), 0);
    end

    $display("[TB] vector table");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].bcd, vecs[i].freq, 1'b1);
      resetDut();
      prev = 0;
      for (int w = 0; w < 5; w++) begin
        waitValid(600, cycles, highs);
        checkOutput($sformatf("v%0d_spacing%0d", i, w), cycles, 256);
        checkOutput($sformatf("v%0d_highs%0d", i, w), highs, prev);
        checkOutput($sformatf("v%0d_sample%0d", i, w), int'(sample), int'(vecs[i].exp[w]));
        prev = int'(vecs[i].exp[w]);
      end
    end

    $display("[TB] amplitude change mid-period");
    applyStimulus(8'h50, 24'h400000, 1'b1);
    resetDut();
    checkWraps("amp", 2, 0, 0, 64, 0, 0);
    repeat (100) tick();
    ampBcd = 8'h99;
    waitValid(600, cycles, highs);
    checkOutput("amp_spacing_mid", cycles, 156);
    checkOutput("amp_sample_old", int'(sample), 128);
    checkWraps("amp_new", 2, 128, 127, 0, 0, 0);

    $display("[TB] enable dropped at cnt=100");
    applyStimulus(8'h99, 24'h400000, 1'b1);
    resetDut();
    checkWraps("en", 2, 0, 0, 128, 0, 0);
    repeat (100) tick();
    checkOutput("en_pwm_before", int'(pwmOut), 1);
    en = 1'b0;
    tick();
    checkOutput("en_pwm_off", int'(pwmOut), 0);
    cnt = 0;
    highs = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      cnt   += int'(sampleValid);
      highs += int'(pwmOut);
    end
    checkOutput("en_no_valid", cnt, 0);
    checkOutput("en_pwm_low", highs, 0);
    checkOutput("en_sample_held", int'(sample), 128);
    en = 1'b1;
    checkWraps("en_resume", 2, 128, 255, 127, 0, 0);

    $display("[TB] asynchronous reset mid-period");
    applyStimulus(8'h99, 24'h400000, 1'b1);
    resetDut();
    checkWraps("arst", 2, 0, 0, 128, 0, 0);
    repeat (50) tick();
    checkOutput("arst_pwm_before", int'(pwmOut), 1);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("arst_pwm", int'(pwmOut), 0);
    checkOutput("arst_sample", int'(sample), 0);
    checkOutput("arst_valid", int'(sampleValid), 0);
    tick();
    rstN = 1'b1;
    checkWraps("arst_restart", 3, 0, 0, 128, 255, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/amp_wave_pwm.md
Name: amp_wave_pwm

Overview:
Downstream consumer of the encoder/decoder amplitude setting. Takes the two-digit BCD amplitude (00–99 %, tens in the high nibble, the same bus that drives the seven-segment digits) and generates a triangle wave. A phase accumulator runs the wave, the amplitude percentage scales it, and the block outputs one-bit PWM for an external RC DAC plus the 8-bit sample for debug.

Parameters:
PHASE_W, 24, phase accumulator width; frequency step = freq_word × f_sample / 2^PHASE_W.
PWM_W, 8, PWM counter and sample width; fixed at 8 (the scaling constant depends on it).

Ports:
clk  input  1  system clock, 12 MHz
rst_n  input  1  asynchronous active-low reset
en  input  1  run enable; low = output parked
amp_bcd  input  8  [7:4] tens digit, [3:0] ones digit, both BCD
freq_word  input  PHASE_W  phase increment per sample period
pwm_out  output  1  PWM output, registered
sample  output  8  duty value currently being output
sample_valid  output  1  one-cycle pulse when sample updates

Behaviour:
- Reset (asynchronous, rst_n=0): all registers clear. pwm_out=0, sample=0, sample_valid=0, cnt=0, phase=0, amp_lat=0.
- BCD to binary, registered: amp_bin = 10×tens + ones. Any nibble >9 is clamped to 9 before conversion, so 8'hAF gives 99.
- PWM counter cnt (8 bits):
  - increments every clock while en=1 and wraps 255→0;
  - one period is 256 clocks, giving 46.875 kHz at 12 MHz.
- Events on the wrap edge (cnt==255 and en=1), all on the same edge:
  - sample ← scaled(phase, amp_lat);
  - sample_valid=1 for exactly that next cycle;
  - phase ← phase + freq_word, modulo 2^PHASE_W;
  - amp_lat ← amp_bin.
- Triangle generation from the phase MSBs:
  - t = phase[PHASE_W-2 -: 8];
  - tri = phase[PHASE_W-1] ? ~t : t;
  - range 0..255, one peak per phase cycle.
- Scaling:
  - scaled = (tri × amp_lat × 662) >> 16, with 25-bit intermediate;
  - amp=99 reproduces tri exactly; amp=0 gives 0; the result never exceeds 255.
  - Pipelining (≤3 stages) is allowed, because phase and amp_lat are stable for 255 cycles before use.
- Latency:
  - A change on amp_bcd is reflected in sample at the second wrap after it is applied (≤ 513 clocks).
  - phase advances once per period.
- PWM comparison: pwm_out ← (en && cnt < sample), registered, so the comparison is one clock late relative to cnt.
  - sample=0 gives constantly low.
  - sample=255 gives high 255 of every 256 clocks.
- en=0:
  - cnt is forced to 0 and phase holds;
  - sample holds its value and sample_valid=0;
  - pwm_out=0 from the next edge onward.
  - When en rises, counting resumes from cnt=0 and the first wrap occurs 256 clocks later.
- freq_word=0: phase is frozen, giving a DC duty equal to the current scaled value.
- Phase wrap: modular with no sticky state; a triangle discontinuity is impossible.
- Reset mid-period: immediate asynchronous clear. The first wrap occurs 256 clocks after release.

Decomposition:
- Shared package constants: PWM_W=8, SCALE_K=662, SCALE_SH=16, BCD_MAX=9.
- Natural sub-module bcd2bin_clamp: 8-bit BCD in, 7-bit binary out, registered. It is reusable by other setting consumers.
- Counter, accumulator, scaling and comparator stay in the top module.

Test Plan:
1. Reset held, toggling inputs -> pwm_out=0, sample=0, sample_valid=0 throughout. After release with en=1, the first sample_valid pulse arrives 256 clocks later.
2. amp_bcd=8'h99, freq_word=2^22, en=1 -> after the latch settles, successive samples run 0,128,255,127 and repeat. Each pulse is exactly one clock, at a 256-clock spacing. pwm high count per period equals sample.
3. Same stimulus with amp_bcd=8'h50 -> samples 0,64,128,64 repeating. Changing to 8'h99 mid-period takes effect at the second following wrap.
4. amp_bcd=8'h00 -> sample=0 and pwm_out never high. amp_bcd=8'hAF -> behaves identically to 8'h99.
5. en dropped mid-period at cnt=100 -> pwm_out=0 next cycle, phase and sample held, no sample_valid pulse. en re-raised -> wrap exactly 256 clocks later, and the phase sequence continues where it stopped.
6. rst_n pulsed low asynchronously between clock edges mid-period -> outputs clear without waiting for a clock edge, and the sequence restarts from phase 0.
